// File: rtl/brick_pkg.sv
// rtl/brick_pkg.sv - shared FSM state type, default geometry and width helpers for the brick field
package brick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_CLEAR = 2'd3
  } brick_state_e;

  localparam int DEF_ROWS    = 7;
  localparam int DEF_COLS    = 16;
  localparam int DEF_BRICK_W = 2;

  // Number of bricks in a ROWS x COLS grid of BRICK_W-wide bricks
  function automatic int brick_count(input int rows, input int cols, input int brick_w);
    return rows * (cols / brick_w);
  endfunction

  // Width of a brick index; never below one bit so tiny fields still elaborate
  function automatic int index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/brick_index_calc.sv
// rtl/brick_index_calc.sv - maps a ball (row, col) cell to a brick index and in-field flag
module brick_index_calc
  import brick_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int IDX_W   = index_width(brick_count(ROWS, COLS, BRICK_W))
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam int BPR = COLS / BRICK_W;

  // Out-of-field positions report index 0 so callers never address past the array
  always_comb begin
    valid = (32'(row) < 32'(ROWS)) && (32'(col) < 32'(COLS));
    idx   = valid ? IDX_W'(32'(row) * 32'(BPR) + 32'(col) / 32'(BRICK_W)) : '0;
  end

endmodule

// File: rtl/brick_field_scorer.sv
// rtl/brick_field_scorer.sv - brick hit-point field, collision resolution, score and level tracking
module brick_field_scorer
  import brick_pkg::*;
#(
  parameter  int ROWS     = DEF_ROWS,
  parameter  int COLS     = DEF_COLS,
  parameter  int BRICK_W  = DEF_BRICK_W,
  parameter  int ROW_W    = 4,
  parameter  int COL_W    = 4,
  parameter  int HP_W     = 2,
  parameter  int INIT_HP  = 1,
  parameter  int SCORE_W  = 10,
  parameter  int PTS_HIT  = 1,
  parameter  int PTS_KILL = 1,
  localparam int NB       = brick_count(ROWS, COLS, BRICK_W),
  localparam int IDX_W    = index_width(NB)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  logic [ROW_W-1:0]   ball_row,
  input  logic [COL_W-1:0]   ball_col,
  output logic [NB-1:0]      brick_alive,
  output logic               hit,
  output logic               hit_kill,
  output logic [IDX_W-1:0]   hit_index,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         level,
  output logic               level_clear,
  output logic               busy
);

  localparam int CNT_W = $clog2(NB + 1);

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] PLAY  = 2'(ST_PLAY);
  localparam logic [1:0] CHECK = 2'(ST_CHECK);
  localparam logic [1:0] CLEAR = 2'(ST_CLEAR);

  logic [1:0]         state;
  logic [ROW_W-1:0]   lat_row;
  logic [COL_W-1:0]   lat_col;
  logic [HP_W-1:0]    hp      [NB];
  logic [HP_W-1:0]    hp_next [NB];
  logic [CNT_W-1:0]   remaining;
  logic [IDX_W-1:0]   calc_idx;
  logic               calc_valid;
  logic [HP_W-1:0]    hp_sel;
  logic               do_hit;
  logic               kill;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  brick_index_calc #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .BRICK_W (BRICK_W),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W),
    .IDX_W   (IDX_W)
  ) u_index_calc (
    .row   (lat_row),
    .col   (lat_col),
    .idx   (calc_idx),
    .valid (calc_valid)
  );

  assign busy = (state == CHECK);

  // Look up the addressed brick and decide whether this CHECK cycle lands a hit
  always_comb begin
    hp_sel = '0;
    for (int i = 0; i < NB; i++) begin
      if (calc_idx == IDX_W'(i)) hp_sel = hp[i];
    end
    do_hit = (state == CHECK) && calc_valid && (hp_sel != '0);
    kill   = (hp_sel == HP_W'(1));
  end

  // Saturating score: one extra carry bit detects overflow and clamps to all ones
  always_comb begin
    score_sum  = {1'b0, score} + (kill ? (SCORE_W+1)'(PTS_KILL) : (SCORE_W+1)'(PTS_HIT));
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // Next hit points: start reloads the whole field, otherwise only the hit brick drops by one
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      hp_next[i] = hp[i];
      if (start) begin
        hp_next[i] = HP_W'(INIT_HP);
      end else if (do_hit && (calc_idx == IDX_W'(i))) begin
        hp_next[i] = hp[i] - HP_W'(1);
      end
    end
  end

  // Hit-point storage with its registered alive mirror, both updated on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        hp[i]          <= '0;
        brick_alive[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        hp[i]          <= hp_next[i];
        brick_alive[i] <= (hp_next[i] != '0);
      end
    end
  end

  // Game FSM with score, level, remaining-brick count and hit reporting; start overrides everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_row     <= '0;
      lat_col     <= '0;
      remaining   <= '0;
      score       <= '0;
      level       <= '0;
      hit         <= 1'b0;
      hit_kill    <= 1'b0;
      hit_index   <= '0;
      level_clear <= 1'b0;
    end else begin
      hit      <= 1'b0;
      hit_kill <= 1'b0;
      if (start) begin
        state       <= PLAY;
        remaining   <= CNT_W'(NB);
        level_clear <= 1'b0;
        if (state == CLEAR) level <= level + 8'd1;
      end else begin
        case (state)
          IDLE: ;
          PLAY: begin
            if (step) begin
              lat_row <= ball_row;
              lat_col <= ball_col;
              state   <= CHECK;
            end
          end
          CHECK: begin
            state <= PLAY;
            if (do_hit) begin
              hit       <= 1'b1;
              hit_kill  <= kill;
              hit_index <= calc_idx;
              score     <= score_next;
              if (kill) begin
                remaining <= remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                  state       <= CLEAR;
                  level_clear <= 1'b1;
                end
              end
            end
          end
          CLEAR: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brick_field_scorer.sv
// tb/tb_brick_field_scorer.sv - randomized and directed checks of brick_field_scorer against a behavioural model
module tb_brick_field_scorer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // instance 0: default geometry; instance 1: 2x4 field, 2 hp, kill bonus, 4-bit score
  logic        start_a, step_a, start_b, step_b;
  logic [3:0]  row_a, col_a, row_b, col_b;
  logic [55:0] alive_a;
  logic        hit_a, kill_a, clear_a, busy_a;
  logic [5:0]  hidx_a;
  logic [9:0]  score_a;
  logic [7:0]  level_a;
  logic [3:0]  alive_b;
  logic        hit_b, kill_b, clear_b, busy_b;
  logic [1:0]  hidx_b;
  logic [3:0]  score_b;
  logic [7:0]  level_b;

  brick_field_scorer u_dut_a (
    .clock(clock), .reset(reset), .start(start_a), .step(step_a),
    .ball_row(row_a), .ball_col(col_a), .brick_alive(alive_a),
    .hit(hit_a), .hit_kill(kill_a), .hit_index(hidx_a), .score(score_a),
    .level(level_a), .level_clear(clear_a), .busy(busy_a)
  );

  brick_field_scorer #(
    .ROWS(2), .COLS(4), .BRICK_W(2), .INIT_HP(2),
    .PTS_HIT(1), .PTS_KILL(5), .SCORE_W(4)
  ) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b), .step(step_b),
    .ball_row(row_b), .ball_col(col_b), .brick_alive(alive_b),
    .hit(hit_b), .hit_kill(kill_b), .hit_index(hidx_b), .score(score_b),
    .level(level_b), .level_clear(clear_b), .busy(busy_b)
  );

  int cfg_rows [2] = '{7, 2};
  int cfg_cols [2] = '{16, 4};
  int cfg_nb   [2] = '{56, 4};
  int cfg_init [2] = '{1, 2};
  int cfg_ph   [2] = '{1, 1};
  int cfg_pk   [2] = '{1, 5};
  int cfg_smax [2] = '{1023, 15};

  int m_hp [2][56];
  int m_score [2];
  int m_level [2];
  int m_hidx [2];
  bit m_started [2];
  bit m_clear [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_alive(input int k);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < cfg_nb[k]; i++) v[i] = (m_hp[k][i] > 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 56; i++) m_hp[k][i] = 0;
      m_score[k] = 0; m_level[k] = 0; m_hidx[k] = 0;
      m_started[k] = 1'b0; m_clear[k] = 1'b0;
    end
  endtask

  task automatic model_start(input int k);
    if (m_clear[k]) m_level[k] = (m_level[k] + 1) % 256;
    m_clear[k] = 1'b0;
    m_started[k] = 1'b1;
    for (int i = 0; i < cfg_nb[k]; i++) m_hp[k][i] = cfg_init[k];
  endtask

  task automatic model_step(input int k, input int r, input int c, output bit mh, output bit mk);
    mh = 1'b0;
    mk = 1'b0;
    if (m_started[k] && !m_clear[k] && r < cfg_rows[k] && c < cfg_cols[k]) begin
      int idx;
      idx = r * (cfg_cols[k] / 2) + c / 2;
      if (m_hp[k][idx] > 0) begin
        m_hp[k][idx] = m_hp[k][idx] - 1;
        mh = 1'b1;
        mk = (m_hp[k][idx] == 0);
        m_score[k] = m_score[k] + (mk ? cfg_pk[k] : cfg_ph[k]);
        if (m_score[k] > cfg_smax[k]) m_score[k] = cfg_smax[k];
        m_hidx[k] = idx;
        if (m_alive(k) == 64'd0) m_clear[k] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int k, input logic st, input logic sp, input int r, input int c);
    if (k == 0) begin
      start_a = st; step_a = sp; row_a = 4'(r); col_a = 4'(c);
    end else begin
      start_b = st; step_b = sp; row_b = 4'(r); col_b = 4'(c);
    end
  endtask

  task automatic observe(input int k, output logic [63:0] al, output logic h, output logic hk,
                         output logic [63:0] hx, output logic [63:0] sc, output logic [63:0] lv,
                         output logic lc, output logic bs);
    if (k == 0) begin
      al = 64'(alive_a); h = hit_a; hk = kill_a; hx = 64'(hidx_a);
      sc = 64'(score_a); lv = 64'(level_a); lc = clear_a; bs = busy_a;
    end else begin
      al = 64'(alive_b); h = hit_b; hk = kill_b; hx = 64'(hidx_b);
      sc = 64'(score_b); lv = 64'(level_b); lc = clear_b; bs = busy_b;
    end
  endtask

  task automatic check_all(input int k, input string tag, input bit eh, input bit ek, input bit eb);
    logic [63:0] al, hx, sc, lv;
    logic h, hk, lc, bs;
    observe(k, al, h, hk, hx, sc, lv, lc, bs);
    check_eq({tag, ".alive"}, al, m_alive(k));
    check_eq({tag, ".hit"}, 64'(h), 64'(eh));
    check_eq({tag, ".hit_kill"}, 64'(hk), 64'(ek));
    check_eq({tag, ".hit_index"}, hx, 64'(m_hidx[k]));
    check_eq({tag, ".score"}, sc, 64'(m_score[k]));
    check_eq({tag, ".level"}, lv, 64'(m_level[k]));
    check_eq({tag, ".level_clear"}, 64'(lc), 64'(m_clear[k]));
    check_eq({tag, ".busy"}, 64'(bs), 64'(eb));
  endtask

  // step strobe at edge N (optionally held into CHECK, where it must be dropped), result checked after N+1
  task automatic do_step(input int k, input int r, input int c, input bit held, input string tag);
    bit mh, mk, active;
    logic [63:0] al, hx, sc, lv;
    logic h, hk, lc, bs;
    active = m_started[k] && !m_clear[k];
    drive(k, 1'b0, 1'b1, r, c);
    tick();
    if (!held) drive(k, 1'b0, 1'b0, r, c);
    observe(k, al, h, hk, hx, sc, lv, lc, bs);
    check_eq({tag, ".hit_n"}, 64'(h), 64'd0);
    check_eq({tag, ".busy_n"}, 64'(bs), 64'(active));
    tick();
    drive(k, 1'b0, 1'b0, r, c);
    model_step(k, r, c, mh, mk);
    check_all(k, tag, mh, mk, 1'b0);
  endtask

  task automatic do_start(input int k, input bit with_step, input string tag);
    drive(k, 1'b1, with_step, 0, 0);
    tick();
    drive(k, 1'b0, 1'b0, 0, 0);
    model_start(k);
    check_all(k, tag, 1'b0, 1'b0, 1'b0);
  endtask

  // step accepted, then start lands during CHECK and discards the pending collision
  task automatic start_in_check(input int k, input int r, input int c, input string tag);
    logic [63:0] al, hx, sc, lv;
    logic h, hk, lc, bs;
    drive(k, 1'b0, 1'b1, r, c);
    tick();
    observe(k, al, h, hk, hx, sc, lv, lc, bs);
    check_eq({tag, ".busy_chk"}, 64'(bs), 64'd1);
    drive(k, 1'b1, 1'b0, r, c);
    tick();
    drive(k, 1'b0, 1'b0, r, c);
    model_start(k);
    check_all(k, tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] al, hx, sc, lv;
    logic h, hk, lc, bs;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    model_reset();
    tick();
    tick();
    check_all(0, "rst_a", 1'b0, 1'b0, 1'b0);
    check_all(1, "rst_b", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // default geometry directed cases
    do_step(0, 0, 0, 1'b0, "a_pre_start");
    do_start(0, 1'b0, "a_start");
    check_eq("a_start.all_alive", 64'(alive_a), 64'h00FF_FFFF_FFFF_FFFF);
    do_step(0, 0, 0, 1'b0, "a_00");
    check_eq("a_00.score_const", 64'(score_a), 64'd1);
    check_eq("a_00.alive0_const", 64'(alive_a[0]), 64'd0);
    do_step(0, 3, 5, 1'b0, "a_35");
    check_eq("a_35.idx_const", 64'(hidx_a), 64'd26);
    do_step(0, 3, 4, 1'b0, "a_34");
    check_eq("a_34.score_const", 64'(score_a), 64'd2);
    do_step(0, 7, 3, 1'b0, "a_row7");
    do_step(0, 15, 15, 1'b0, "a_row15");
    do_step(0, 6, 15, 1'b1, "a_held");

    // small field: multi-hp bricks, kill bonus, clamping, level clear
    do_start(1, 1'b0, "b_start");
    do_step(1, 0, 2, 1'b0, "b_02a");
    check_eq("b_02a.score_const", 64'(score_b), 64'd1);
    do_step(1, 0, 2, 1'b0, "b_02b");
    check_eq("b_02b.score_const", 64'(score_b), 64'd6);
    do_step(1, 0, 0, 1'b1, "b_held");
    do_step(1, 0, 0, 1'b0, "b_00");
    do_step(1, 1, 0, 1'b0, "b_10a");
    do_step(1, 1, 1, 1'b0, "b_11");
    check_eq("b_11.clamp_const", 64'(score_b), 64'd15);
    do_step(1, 1, 2, 1'b0, "b_12a");
    do_step(1, 1, 3, 1'b0, "b_13");
    check_eq("b_13.clear_const", 64'(clear_b), 64'd1);
    do_step(1, 0, 0, 1'b0, "b_in_clear");
    do_start(1, 1'b0, "b_restart");
    check_eq("b_restart.level_const", 64'(level_b), 64'd1);
    check_eq("b_restart.alive_const", 64'(alive_b), 64'hF);
    do_step(1, 1, 1, 1'b0, "b_after");
    do_start(1, 1'b1, "b_start_step");
    start_in_check(1, 0, 1, "b_start_chk");

    // randomized traffic on both fields
    for (int n = 0; n < 160; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 5) do_start(0, sel[0], "a_rnd_start");
      else do_step(0, int'($urandom_range(0, 9)), int'($urandom_range(0, 15)), (sel % 8) == 0, "a_rnd");
    end
    for (int n = 0; n < 120; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 6) do_start(1, sel[0], "b_rnd_start");
      else if (sel < 9 && m_started[1] && !m_clear[1]) start_in_check(1, 0, 0, "b_rnd_chk");
      else do_step(1, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), (sel % 8) == 0, "b_rnd");
    end

    // asynchronous reset while instance a sits in CHECK
    do_start(0, 1'b0, "a_prerst");
    drive(0, 1'b0, 1'b1, 2, 2);
    tick();
    drive(0, 1'b0, 1'b0, 2, 2);
    observe(0, al, h, hk, hx, sc, lv, lc, bs);
    check_eq("a_rst_chk.busy", 64'(bs), 64'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(0, "a_rst_mid", 1'b0, 1'b0, 1'b0);
    check_all(1, "b_rst_mid", 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_all(0, "a_post_rst", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
